// File: rtl/cont_servo_test_mss.sv
// Servo bring-up controller: UART speed commands (echoed back) set the pulse width of a 50 Hz servo PWM.
// The I2C_1 pins are reserved and always released.
//
// state    | RX meaning                          | TX meaning
// IDLE     | wait for falling edge on line       | wait for an accepted byte
// START    | half-bit wait, confirm start is low | drive start bit
// DATA     | sample 8 bits at bit centres        | drive 8 data bits, LSB first
// STOP     | check stop bit, flag valid byte     | drive stop bit
module cont_servo_test_mss #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PERIOD_CLKS  = 200000,
    parameter int PULSE_MIN    = 9880,
    parameter int PULSE_STEP   = 40,
    parameter int CMD_RESET    = 128
) (
    input  logic SYSCLK,
    input  logic MSS_RESET,
    input  logic UART_0_RXD,
    output logic UART_0_TXD,
    output logic M2F_GPO_0,
    inout  wire  I2C_1_SDA,
    inout  wire  I2C_1_SCL
);

    localparam int BW = $clog2(CLKS_PER_BIT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [17:0]   CNT_LAST  = 18'(PERIOD_CLKS - 1);

    assign I2C_1_SDA = 1'bz;
    assign I2C_1_SCL = 1'bz;

    // Reset asserts immediately, releases on a clock edge
    logic [1:0] rst_pipe;
    logic       rst;

    always_ff @(posedge SYSCLK or posedge MSS_RESET) begin
        if (MSS_RESET) rst_pipe <= 2'b11;
        else           rst_pipe <= {rst_pipe[0], 1'b0};
    end

    assign rst = rst_pipe[1];

    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge SYSCLK or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= UART_0_RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    logic [1:0]    rx_state;
    logic [BW-1:0] rx_timer;
    logic [2:0]    rx_idx;
    logic [7:0]    rx_shift;
    logic          rx_valid;

    always_ff @(posedge SYSCLK or posedge rst) begin
        if (rst) begin
            rx_state <= ST_IDLE;
            rx_timer <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_state <= ST_START;
                        rx_timer <= HALF_LAST;
                    end
                end
                ST_START: begin
                    if (rx_timer == '0) begin
                        if (rx_s2) begin
                            rx_state <= ST_IDLE;
                        end else begin
                            rx_state <= ST_DATA;
                            rx_timer <= BIT_LAST;
                            rx_idx   <= '0;
                        end
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_timer == '0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_timer <= BIT_LAST;
                        if (rx_idx == 3'd7) rx_state <= ST_STOP;
                        else                rx_idx   <= rx_idx + 1'b1;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
                default: begin
                    if (rx_timer == '0) begin
                        rx_valid <= rx_s2;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_timer <= rx_timer - 1'b1;
                    end
                end
            endcase
        end
    end

    logic [7:0] cmd;

    always_ff @(posedge SYSCLK or posedge rst) begin
        if (rst)           cmd <= 8'(CMD_RESET);
        else if (rx_valid) cmd <= rx_shift;
    end

    // Echo is attempted only when TX is idle; otherwise the byte is dropped from the echo path
    logic [1:0]    tx_state;
    logic [BW-1:0] tx_timer;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_shift;

    always_ff @(posedge SYSCLK or posedge rst) begin
        if (rst) begin
            tx_state   <= ST_IDLE;
            tx_timer   <= '0;
            tx_idx     <= '0;
            tx_shift   <= '0;
            UART_0_TXD <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        tx_shift   <= rx_shift;
                        tx_timer   <= BIT_LAST;
                        tx_state   <= ST_START;
                        UART_0_TXD <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tx_timer == '0) begin
                        UART_0_TXD <= tx_shift[0];
                        tx_shift   <= {1'b0, tx_shift[7:1]};
                        tx_idx     <= '0;
                        tx_timer   <= BIT_LAST;
                        tx_state   <= ST_DATA;
                    end else begin
                        tx_timer <= tx_timer - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_timer == '0) begin
                        tx_timer <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            UART_0_TXD <= 1'b1;
                            tx_state   <= ST_STOP;
                        end else begin
                            UART_0_TXD <= tx_shift[0];
                            tx_shift   <= {1'b0, tx_shift[7:1]};
                            tx_idx     <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_timer <= tx_timer - 1'b1;
                    end
                end
                default: begin
                    if (tx_timer == '0) tx_state <= ST_IDLE;
                    else                tx_timer <= tx_timer - 1'b1;
                end
            endcase
        end
    end

    // Width is only re-latched at count 0 so a command never reshapes a frame in flight
    logic [17:0] pwm_cnt;
    logic [17:0] width;
    logic [17:0] new_width;
    logic [17:0] eff_width;

    assign new_width = 18'(PULSE_MIN) + 18'(cmd) * 18'(PULSE_STEP);
    assign eff_width = (pwm_cnt == '0) ? new_width : width;

    always_ff @(posedge SYSCLK or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            width     <= 18'(PULSE_MIN + CMD_RESET * PULSE_STEP);
            M2F_GPO_0 <= 1'b0;
        end else begin
            width     <= eff_width;
            M2F_GPO_0 <= (pwm_cnt < eff_width);
            pwm_cnt   <= (pwm_cnt == CNT_LAST) ? '0 : pwm_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_cont_servo_test_mss.sv
// Directed bench for cont_servo_test_mss: UART echo framing, PWM widths per command, framing errors,
// start-bit glitches, mid-frame updates and reset in the middle of traffic.
module tb_cont_servo_test_mss;

    localparam int CB    = 87;
    localparam int PER   = 2500;
    localparam int PMIN  = 988;
    localparam int PSTEP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    wire  txd, gpo;
    wire  sda, scl;

    pullup (sda);
    pullup (scl);

    always #5 clk = ~clk;

    cont_servo_test_mss #(
        .CLKS_PER_BIT(CB),
        .PERIOD_CLKS (PER),
        .PULSE_MIN   (PMIN),
        .PULSE_STEP  (PSTEP),
        .CMD_RESET   (128)
    ) dut (
        .SYSCLK    (clk),
        .MSS_RESET (rst),
        .UART_0_RXD(rxd),
        .UART_0_TXD(txd),
        .M2F_GPO_0 (gpo),
        .I2C_1_SDA (sda),
        .I2C_1_SCL (scl)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         echo;
        int         width;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic uart_send(input logic [7:0] b, input bit stop_ok);
        logic bitv;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      bitv = 1'b0;
            else if (i == 9) bitv = stop_ok;
            else             bitv = b[i-1];
            rxd = bitv;
            repeat (CB) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic capture_echo(input logic [7:0] d, input bit expect_echo, input string name);
        int         waited;
        bit         found;
        int         bad;
        logic [9:0] f;
        waited = 0;
        found  = 1'b0;
        bad    = 0;
        while (!found && waited < 12 * CB) begin
            @(negedge clk);
            waited++;
            if (txd == 1'b0) found = 1'b1;
        end
        if (!expect_echo) begin
            check($sformatf("%s no_echo", name), int'(found), 0);
            return;
        end
        if (!found) begin
            check($sformatf("%s echo_start", name), 0, 1);
            return;
        end
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10 * CB; i++) begin
            if (txd !== f[i / CB]) bad++;
            @(negedge clk);
        end
        if (txd !== 1'b1) bad++;
        check($sformatf("%s echo_bad_samples", name), bad, 0);
    endtask

    task automatic wait_rise(output bit ok);
        logic prev;
        prev = gpo;
        ok   = 1'b0;
        for (int i = 0; i < 2 * PER + 10; i++) begin
            @(negedge clk);
            if (!prev && gpo) begin
                ok = 1'b1;
                break;
            end
            prev = gpo;
        end
    endtask

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (gpo === lvl && n < PER + 10) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_frame(input string name, input int exp_high);
        bit ok;
        int hi;
        int lo;
        wait_rise(ok);
        check($sformatf("%s pwm_rise", name), int'(ok), 1);
        if (!ok) return;
        count_level(1'b1, hi);
        count_level(1'b0, lo);
        check($sformatf("%s pwm_high", name), hi, exp_high);
        check($sformatf("%s pwm_period", name), hi + lo, PER);
    endtask

    initial begin
        #(99000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        bit found;
        int hi;
        int waited;

        vecs[0] = '{8'h00, 1'b1, 1'b1, PMIN};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, PMIN + 165 * PSTEP};
        vecs[2] = '{8'h40, 1'b0, 1'b0, PMIN + 165 * PSTEP};
        vecs[3] = '{8'h01, 1'b1, 1'b1, PMIN + PSTEP};
        vecs[4] = '{8'h80, 1'b1, 1'b1, PMIN + 128 * PSTEP};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, PMIN + 255 * PSTEP};

        rst = 1'b1;
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("reset txd", int'(txd), 1);
        check("reset gpo", int'(gpo), 0);
        check("reset sda released", int'(sda), 1);
        check("reset scl released", int'(scl), 1);
        rst = 1'b0;

        measure_frame("first_frame", PMIN + 128 * PSTEP);
        check("idle txd", int'(txd), 1);
        check("idle sda released", int'(sda), 1);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            fork
                uart_send(vecs[i].data, vecs[i].stop_ok);
                capture_echo(vecs[i].data, vecs[i].echo, $sformatf("vec%0d", i));
            join
            measure_frame($sformatf("vec%0d", i), vecs[i].width);
        end

        // command lands while a 0xFF-width pulse is still high
        wait_rise(ok);
        check("midframe rise", int'(ok), 1);
        fork
            uart_send(8'h00, 1'b1);
            count_level(1'b1, hi);
        join
        check("midframe width held", hi, PMIN + 255 * PSTEP);
        measure_frame("after_midframe", PMIN);

        @(negedge clk);
        fork
            begin
                uart_send(8'h10, 1'b1);
                uart_send(8'h20, 1'b1);
            end
            capture_echo(8'h10, 1'b1, "b2b_first");
        join
        measure_frame("b2b_last_wins", PMIN + 32 * PSTEP);

        @(negedge clk);
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        capture_echo(8'h00, 1'b0, "glitch");
        measure_frame("glitch", PMIN + 32 * PSTEP);

        wait_rise(ok);
        check("reset_midop rise", int'(ok), 1);
        fork
            uart_send(8'hA5, 1'b1);
            begin
                found  = 1'b0;
                waited = 0;
                while (!found && waited < 12 * CB) begin
                    @(negedge clk);
                    waited++;
                    if (txd == 1'b0) found = 1'b1;
                end
                check("reset_midop echo_start", int'(found), 1);
                repeat (20) @(negedge clk);
                check("reset_midop pre gpo", int'(gpo), 1);
                check("reset_midop pre txd", int'(txd), 0);
                #2 rst = 1'b1;
                #1;
                check("reset_midop async txd", int'(txd), 1);
                check("reset_midop async gpo", int'(gpo), 0);
            end
        join
        repeat (10) @(negedge clk);
        check("reset_midop sda released", int'(sda), 1);
        rst = 1'b0;
        measure_frame("post_reset", PMIN + 128 * PSTEP);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
